// File: rtl/line_fill_pkg.sv
// Shared types and constants for the cache line fill sequencer.
package line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int NUM_WORDS = 8;
    localparam int SEL_W     = 3;

endpackage

// File: rtl/line_fill_ctrl.sv
// Critical-word-first line fill sequencer: turns memory beats into
// word select / write enable for the line buffer's 8-line decoder.
module line_fill_ctrl
    import line_fill_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [SEL_W-1:0] i_start_offset,
    input  logic             i_mem_resp,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic             o_mem_read,
    output logic [SEL_W-1:0] o_word_sel,
    output logic             o_word_we,
    output logic [WIDTH-1:0] o_word_data,
    output logic             o_critical,
    output logic             o_busy,
    output logic             o_done
);

    fill_state_t      r_state;
    fill_state_t      w_next_state;
    logic [SEL_W-1:0] r_base;
    logic [SEL_W:0]   r_beat_cnt;
    logic             w_word_we;
    logic             w_last_beat;

    // State register; reset abandons any fill in progress.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus all outputs (status from state only, beat path combinational).
    always_comb begin
        w_next_state = r_state;
        o_mem_read   = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        w_word_we    = 1'b0;
        w_last_beat  = (r_beat_cnt == 4'(NUM_WORDS - 1));

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                o_mem_read = 1'b1;
                o_busy     = 1'b1;
                w_word_we  = i_mem_resp;
                if (i_mem_resp && w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        o_word_we   = w_word_we;
        o_word_sel  = r_base + r_beat_cnt[SEL_W-1:0];
        o_word_data = i_mem_rdata;
        o_critical  = w_word_we && (r_beat_cnt == '0);
    end

    // Critical-word base and beat counter; base is captured only when a fill is accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_base     <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_base     <= i_start_offset;
            r_beat_cnt <= '0;
        end else if (w_word_we) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl: vector table plus reset/refill sequences.
module tb_line_fill_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  start_offset;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_read;
    logic [2:0]  word_sel;
    logic        word_we;
    logic [15:0] word_data;
    logic        critical;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start;
        logic [2:0]  off;
        logic        resp;
        logic [15:0] data;
        logic        mr;
        logic        we;
        logic [2:0]  sel;
        logic        crit;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    line_fill_ctrl #(.WIDTH(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_start_offset (start_offset),
        .i_mem_resp     (mem_resp),
        .i_mem_rdata    (mem_rdata),
        .o_mem_read     (mem_read),
        .o_word_sel     (word_sel),
        .o_word_we      (word_we),
        .o_word_data    (word_data),
        .o_critical     (critical),
        .o_busy         (busy),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_v(input logic s, input logic [2:0] o, input logic r, input logic [15:0] d,
                         input logic mr, input logic we, input logic [2:0] sel,
                         input logic cr, input logic bz, input logic dn);
        vec_t v;
        v.start = s; v.off = o; v.resp = r; v.data = d;
        v.mr = mr; v.we = we; v.sel = sel; v.crit = cr; v.busy = bz; v.done = dn;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic r, input logic [15:0] d);
        start = s; start_offset = o; mem_resp = r; mem_rdata = d;
    endtask

    initial begin
        logic [2:0] sel5 [8];
        logic [2:0] sel2 [8];
        logic [2:0] sel3 [3];
        logic [2:0] sel7 [8];
        sel5 = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        sel2 = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        sel3 = '{3'd3, 3'd4, 3'd5};
        sel7 = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

        // Fill at offset 0, start taken in IDLE with a stray beat present.
        add_v(1, 3'd0, 1, 16'hDEAD, 0, 0, 3'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add_v(0, 3'd0, 1, 16'h1000 + 16'(i), 1, 1, 3'(i), i == 0, 1, 0);
        add_v(0, 3'd0, 0, 16'h0000, 0, 0, 3'd0, 0, 1, 1);
        // Back-to-back: start in first IDLE cycle after DONE, offset 5; start during FILL/DONE ignored.
        add_v(1, 3'd5, 0, 16'h0000, 0, 0, 3'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add_v(i == 3, 3'd2, 1, 16'h00A0 + 16'(i), 1, 1, sel5[i], i == 0, 1, 0);
        add_v(1, 3'd6, 0, 16'h0000, 0, 0, 3'd5, 0, 1, 1);
        add_v(0, 3'd0, 1, 16'h5555, 0, 0, 3'd5, 0, 0, 0);
        add_v(0, 3'd0, 1, 16'h6666, 0, 0, 3'd5, 0, 0, 0);
        // Offset 2 with two stall cycles after every beat.
        add_v(1, 3'd2, 0, 16'h0000, 0, 0, 3'd5, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add_v(0, 3'd0, 1, 16'h00C0 + 16'(i), 1, 1, sel2[i], i == 0, 1, 0);
            if (i < 7) begin
                add_v(0, 3'd0, 0, 16'hEEEE, 1, 0, sel2[i+1], 0, 1, 0);
                add_v(0, 3'd0, 0, 16'hEEEF, 1, 0, sel2[i+1], 0, 1, 0);
            end
        end
        add_v(0, 3'd0, 0, 16'h0000, 0, 0, 3'd2, 0, 1, 1);
        add_v(0, 3'd0, 0, 16'h0000, 0, 0, 3'd2, 0, 0, 0);

        // Reset state.
        reset = 1'b1;
        drive(0, 3'd0, 0, 16'h0000);
        @(negedge clk);
        #2;
        chk("rst.mem_read", 32'(mem_read), 0);
        chk("rst.word_we", 32'(word_we), 0);
        chk("rst.word_sel", 32'(word_sel), 0);
        chk("rst.critical", 32'(critical), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].off, vecs[i].resp, vecs[i].data);
            #2;
            chk($sformatf("v%0d.mem_read", i), 32'(mem_read), 32'(vecs[i].mr));
            chk($sformatf("v%0d.word_we", i), 32'(word_we), 32'(vecs[i].we));
            chk($sformatf("v%0d.word_sel", i), 32'(word_sel), 32'(vecs[i].sel));
            chk($sformatf("v%0d.word_data", i), 32'(word_data), 32'(vecs[i].data));
            chk($sformatf("v%0d.critical", i), 32'(critical), 32'(vecs[i].crit));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].done));
        end

        // Reset after the third beat of an offset-3 fill.
        @(negedge clk);
        drive(1, 3'd3, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 3'd0, 1, 16'h0300 + 16'(i));
            #2;
            chk($sformatf("mid.sel%0d", i), 32'(word_sel), 32'(sel3[i]));
            chk($sformatf("mid.we%0d", i), 32'(word_we), 1);
        end
        @(negedge clk);
        drive(0, 3'd0, 1, 16'h0303);
        #1;
        chk("mid.we_before_rst", 32'(word_we), 1);
        chk("mid.sel_before_rst", 32'(word_sel), 32'd6);
        #1;
        reset = 1'b1;
        #1;
        chk("mid.rst_mem_read", 32'(mem_read), 0);
        chk("mid.rst_word_we", 32'(word_we), 0);
        chk("mid.rst_busy", 32'(busy), 0);
        chk("mid.rst_done", 32'(done), 0);
        chk("mid.rst_sel", 32'(word_sel), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 3'd0, 1, 16'h0400 + 16'(i));
            #2;
            chk($sformatf("post_rst.done%0d", i), 32'(done), 0);
            chk($sformatf("post_rst.we%0d", i), 32'(word_we), 0);
            chk($sformatf("post_rst.busy%0d", i), 32'(busy), 0);
        end

        // Fresh fill at offset 7 after the abandoned one.
        @(negedge clk);
        drive(1, 3'd7, 0, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, 3'd0, 1, 16'h0700 + 16'(i));
            #2;
            chk($sformatf("f7.sel%0d", i), 32'(word_sel), 32'(sel7[i]));
            chk($sformatf("f7.we%0d", i), 32'(word_we), 1);
            chk($sformatf("f7.crit%0d", i), 32'(critical), (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("f7.data%0d", i), 32'(word_data), 32'h0700 + 32'(i));
            chk($sformatf("f7.done%0d", i), 32'(done), 0);
        end
        @(negedge clk);
        drive(0, 3'd0, 0, 16'h0000);
        #2;
        chk("f7.done", 32'(done), 1);
        chk("f7.done_mem_read", 32'(mem_read), 0);
        @(negedge clk);
        #2;
        chk("f7.idle_done", 32'(done), 0);
        chk("f7.idle_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
